// File: rtl/host_launch_if.sv
// host_launch_if -- request/response channel between the launch sequencer
// and the accelerator's host register port.
//
// Signals:
//   host_req_valid   request present (sequencer -> responder)
//   host_req_opcode  1 = write, 0 = read
//   host_req_addr    register byte address
//   host_req_value   write data, 0 on reads
//   host_req_deq     responder accepts the request this cycle
//   host_resp_valid  read data valid (responder -> sequencer)
//   host_resp_bits   read data
//
// Modports:
//   master  the sequencer side (drives requests, consumes responses)
//   slave   the responder side
interface host_launch_if #(
   parameter int HOST_ADDR_BITS = 8,
   parameter int HOST_DATA_BITS = 32
);
   logic                      host_req_valid;
   logic                      host_req_opcode;
   logic [HOST_ADDR_BITS-1:0] host_req_addr;
   logic [HOST_DATA_BITS-1:0] host_req_value;
   logic                      host_req_deq;
   logic                      host_resp_valid;
   logic [HOST_DATA_BITS-1:0] host_resp_bits;

   modport master (
      output host_req_valid,
      output host_req_opcode,
      output host_req_addr,
      output host_req_value,
      input  host_req_deq,
      input  host_resp_valid,
      input  host_resp_bits
   );

   modport slave (
      input  host_req_valid,
      input  host_req_opcode,
      input  host_req_addr,
      input  host_req_value,
      output host_req_deq,
      output host_resp_valid,
      output host_resp_bits
   );
endinterface

// File: rtl/host_launch_seq.sv
// host_launch_seq -- launches one accelerator run over the host register
// port: writes the configuration registers, kicks the start bit, polls the
// status register until the finish bit is seen (or the poll budget runs
// out), reads back the cycle counter and clears the control register.
//
// Ports:
//   clock          sole clock
//   reset          synchronous, active-high reset
//   start          launch request, only looked at while idle
//   cfg_constant   value written to 0x08
//   cfg_length     value written to 0x0c
//   cfg_inp_baddr  input pointer (low word 0x10, high word 0x14)
//   cfg_out_baddr  output pointer (low word 0x18, high word 0x1c)
//   host           host_launch_if master: request/response channel
//   busy           sequence in progress
//   done           one-cycle pulse when a run completes with a cycle count
//   timeout        one-cycle pulse when the poll budget is exhausted
//   cycles         cycle count read back, held until the next capture
module host_launch_seq #(
   parameter int MEM_ADDR_BITS  = 64,
   parameter int HOST_ADDR_BITS = 8,
   parameter int HOST_DATA_BITS = 32,
   parameter int POLL_GAP       = 4,
   parameter int MAX_POLLS      = 1024
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [HOST_DATA_BITS-1:0] cfg_constant,
   input  logic [HOST_DATA_BITS-1:0] cfg_length,
   input  logic [MEM_ADDR_BITS-1:0]  cfg_inp_baddr,
   input  logic [MEM_ADDR_BITS-1:0]  cfg_out_baddr,
   host_launch_if.master             host,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout,
   output logic [HOST_DATA_BITS-1:0] cycles
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WRITE     = 4'd1,
      ST_LAUNCH    = 4'd2,
      ST_GAP       = 4'd3,
      ST_POLL_REQ  = 4'd4,
      ST_POLL_RESP = 4'd5,
      ST_CNT_REQ   = 4'd6,
      ST_CNT_RESP  = 4'd7,
      ST_CLEAR     = 4'd8,
      ST_FIN       = 4'd9
   } state_t;

   // Register map of the six configuration writes, in issue order.
   function automatic logic [7:0] cfg_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    cfg_addr = 8'h08;
         3'd1:    cfg_addr = 8'h0c;
         3'd2:    cfg_addr = 8'h10;
         3'd3:    cfg_addr = 8'h14;
         3'd4:    cfg_addr = 8'h18;
         3'd5:    cfg_addr = 8'h1c;
         default: cfg_addr = 8'h08;
      endcase
   endfunction

   // Low / high host words of a memory pointer.
   function automatic logic [HOST_DATA_BITS-1:0] ptr_lo(input logic [MEM_ADDR_BITS-1:0] p);
      ptr_lo = HOST_DATA_BITS'(p);
   endfunction

   function automatic logic [HOST_DATA_BITS-1:0] ptr_hi(input logic [MEM_ADDR_BITS-1:0] p);
      ptr_hi = HOST_DATA_BITS'(p >> HOST_DATA_BITS);
   endfunction

   state_t                    state_r;
   state_t                    state_s;
   logic [2:0]                widx_r;
   logic [2:0]                widx_s;
   logic [31:0]               gap_cnt_r;
   logic [31:0]               poll_cnt_r;
   logic                      captured_r;
   logic [HOST_DATA_BITS-1:0] constant_r;
   logic [HOST_DATA_BITS-1:0] length_r;
   logic [MEM_ADDR_BITS-1:0]  inp_r;
   logic [MEM_ADDR_BITS-1:0]  out_r;
   logic [HOST_DATA_BITS-1:0] cycles_r;
   logic                      done_r;
   logic                      timeout_r;
   logic                      busy_r;
   logic                      req_valid_r;
   logic                      req_opcode_r;
   logic [HOST_ADDR_BITS-1:0] req_addr_r;
   logic [HOST_DATA_BITS-1:0] req_value_r;

   logic                      req_valid_s;
   logic                      req_opcode_s;
   logic [HOST_ADDR_BITS-1:0] req_addr_s;
   logic [HOST_DATA_BITS-1:0] req_value_s;

   logic                      xfer_s;
   logic                      latch_s;
   logic                      gap_last_s;
   logic                      poll_limit_s;
   logic                      fin_bit_s;
   logic                      timeout_s;
   logic                      capture_s;
   logic [HOST_DATA_BITS-1:0] constant_nx_s;
   logic [HOST_DATA_BITS-1:0] length_nx_s;
   logic [MEM_ADDR_BITS-1:0]  inp_nx_s;
   logic [MEM_ADDR_BITS-1:0]  out_nx_s;

   assign xfer_s       = req_valid_r & host.host_req_deq;
   assign latch_s      = (state_r == ST_IDLE) & start;
   // GAP exits after its POLL_GAP-th cycle (a zero gap still spends one cycle)
   assign gap_last_s   = ((gap_cnt_r + 32'd1) >= 32'(POLL_GAP));
   assign poll_limit_s = (poll_cnt_r >= 32'(MAX_POLLS));
   assign fin_bit_s    = host.host_resp_bits[1];
   assign timeout_s    = (state_r == ST_POLL_RESP) & host.host_resp_valid & ~fin_bit_s & poll_limit_s;
   assign capture_s    = (state_r == ST_CNT_RESP) & host.host_resp_valid;

   // The first request is built in the same cycle the configuration is
   // latched, so request data comes from the inputs on that cycle.
   assign constant_nx_s = latch_s ? cfg_constant  : constant_r;
   assign length_nx_s   = latch_s ? cfg_length    : length_r;
   assign inp_nx_s      = latch_s ? cfg_inp_baddr : inp_r;
   assign out_nx_s      = latch_s ? cfg_out_baddr : out_r;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         widx_r  <= 3'd0;
      end else begin
         state_r <= state_s;
         widx_r  <= widx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      widx_s  = widx_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_WRITE;
               widx_s  = 3'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (xfer_s) begin
               if (widx_r == 3'd5) begin
                  state_s = ST_LAUNCH;
               end else begin
                  widx_s = widx_r + 3'd1;
               end
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_LAUNCH: begin
            if (xfer_s) state_s = ST_GAP;
            else        state_s = ST_LAUNCH;
         end
         ST_GAP: begin
            if (gap_last_s) state_s = ST_POLL_REQ;
            else            state_s = ST_GAP;
         end
         ST_POLL_REQ: begin
            if (xfer_s) state_s = ST_POLL_RESP;
            else        state_s = ST_POLL_REQ;
         end
         ST_POLL_RESP: begin
            if (host.host_resp_valid) begin
               if (fin_bit_s)         state_s = ST_CNT_REQ;
               else if (poll_limit_s) state_s = ST_CLEAR;
               else                   state_s = ST_GAP;
            end else begin
               state_s = ST_POLL_RESP;
            end
         end
         ST_CNT_REQ: begin
            if (xfer_s) state_s = ST_CNT_RESP;
            else        state_s = ST_CNT_REQ;
         end
         ST_CNT_RESP: begin
            if (host.host_resp_valid) state_s = ST_CLEAR;
            else                      state_s = ST_CNT_RESP;
         end
         ST_CLEAR: begin
            if (xfer_s) state_s = ST_FIN;
            else        state_s = ST_CLEAR;
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            widx_s  = 3'd0;
         end
      endcase
   end

   // Request decode from the next state; registered below so the bus
   // fields stay put while the state waits for its transfer.
   always_comb begin
      req_valid_s  = 1'b0;
      req_opcode_s = 1'b0;
      req_addr_s   = '0;
      req_value_s  = '0;
      case (state_s)
         ST_WRITE: begin
            req_valid_s  = 1'b1;
            req_opcode_s = 1'b1;
            req_addr_s   = HOST_ADDR_BITS'(cfg_addr(widx_s));
            case (widx_s)
               3'd0:    req_value_s = constant_nx_s;
               3'd1:    req_value_s = length_nx_s;
               3'd2:    req_value_s = ptr_lo(inp_nx_s);
               3'd3:    req_value_s = ptr_hi(inp_nx_s);
               3'd4:    req_value_s = ptr_lo(out_nx_s);
               3'd5:    req_value_s = ptr_hi(out_nx_s);
               default: req_value_s = '0;
            endcase
         end
         ST_LAUNCH: begin
            req_valid_s  = 1'b1;
            req_opcode_s = 1'b1;
            req_addr_s   = HOST_ADDR_BITS'(8'h00);
            req_value_s  = HOST_DATA_BITS'(1'b1);
         end
         ST_POLL_REQ: begin
            req_valid_s  = 1'b1;
            req_addr_s   = HOST_ADDR_BITS'(8'h00);
         end
         ST_CNT_REQ: begin
            req_valid_s  = 1'b1;
            req_addr_s   = HOST_ADDR_BITS'(8'h04);
         end
         ST_CLEAR: begin
            req_valid_s  = 1'b1;
            req_opcode_s = 1'b1;
            req_addr_s   = HOST_ADDR_BITS'(8'h00);
         end
         default: begin
            req_valid_s  = 1'b0;
         end
      endcase
   end

   // Registered request and status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         req_valid_r  <= 1'b0;
         req_opcode_r <= 1'b0;
         req_addr_r   <= '0;
         req_value_r  <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         req_valid_r  <= req_valid_s;
         req_opcode_r <= req_opcode_s;
         req_addr_r   <= req_addr_s;
         req_value_r  <= req_value_s;
         busy_r       <= (state_s != ST_IDLE);
         // captured_r is already settled by the time CLEAR hands over to FIN
         done_r       <= (state_s == ST_FIN) & captured_r;
         timeout_r    <= timeout_s;
      end
   end

   // Latched configuration, poll/gap counters and the captured cycle count
   always_ff @(posedge clock) begin
      if (reset) begin
         constant_r <= '0;
         length_r   <= '0;
         inp_r      <= '0;
         out_r      <= '0;
         poll_cnt_r <= 32'd0;
         gap_cnt_r  <= 32'd0;
         captured_r <= 1'b0;
         cycles_r   <= '0;
      end else begin
         if (latch_s) begin
            constant_r <= cfg_constant;
            length_r   <= cfg_length;
            inp_r      <= cfg_inp_baddr;
            out_r      <= cfg_out_baddr;
         end
         // Saturating so the count can never wrap back below the limit
         if (latch_s) begin
            poll_cnt_r <= 32'd0;
         end else if ((state_r == ST_POLL_REQ) && xfer_s && (poll_cnt_r != 32'hFFFF_FFFF)) begin
            poll_cnt_r <= poll_cnt_r + 32'd1;
         end
         if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r + 32'd1;
         end else begin
            gap_cnt_r <= 32'd0;
         end
         if (latch_s) begin
            captured_r <= 1'b0;
         end else if (capture_s) begin
            captured_r <= 1'b1;
         end
         if (capture_s) begin
            cycles_r <= host.host_resp_bits;
         end
      end
   end

   assign host.host_req_valid  = req_valid_r;
   assign host.host_req_opcode = req_opcode_r;
   assign host.host_req_addr   = req_addr_r;
   assign host.host_req_value  = req_value_r;
   assign busy                 = busy_r;
   assign done                 = done_r;
   assign timeout              = timeout_r;
   assign cycles               = cycles_r;

endmodule

// File: tb/tb_host_launch_seq.sv
// tb_host_launch_seq -- directed bench for host_launch_seq with a small
// register-port responder. MAX_POLLS is reduced to 4 so the timeout path
// is reachable in a short run; POLL_GAP keeps its default of 4.
module tb_host_launch_seq;

   localparam int POLL_GAP  = 4;
   localparam int MAX_POLLS = 4;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] cfg_constant;
   logic [31:0] cfg_length;
   logic [63:0] cfg_inp_baddr;
   logic [63:0] cfg_out_baddr;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] cycles;

   host_launch_if #(.HOST_ADDR_BITS(8), .HOST_DATA_BITS(32)) bus ();

   host_launch_seq #(
      .MEM_ADDR_BITS (64),
      .HOST_ADDR_BITS(8),
      .HOST_DATA_BITS(32),
      .POLL_GAP      (POLL_GAP),
      .MAX_POLLS     (MAX_POLLS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .cfg_constant (cfg_constant),
      .cfg_length   (cfg_length),
      .cfg_inp_baddr(cfg_inp_baddr),
      .cfg_out_baddr(cfg_out_baddr),
      .host         (bus),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .cycles       (cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          total = 0;
   int          bad   = 0;
   int          n_done;
   int          n_to;
   logic [40:0] log_q[$];   // {opcode, addr, value} per transfer

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      log_q.delete();
      n_done = 0;
      n_to   = 0;
   endtask

   // Responder: stall cycles of deq=0 per request, finish bit set from the
   // finish_after-th status read on, counter register returns cnt_val.
   task automatic serve(input int stall, input int finish_after, input logic [31:0] cnt_val,
                        input int stop_xfers, input bit spurious, input int budget);
      int          held = 0;
      int          polls = 0;
      int          gap_n = 0;
      bit          pend = 1'b0;
      bit          resp_now;
      bit          gap_trk = 1'b0;
      bit          seen_busy = 1'b0;
      bit          fin = 1'b0;
      logic [31:0] pdata = 32'h0;
      logic [40:0] snap = 41'h0;
      for (int c = 0; c < budget && !fin; c++) begin
         @(negedge clock);
         bus.host_resp_valid = 1'b0;
         bus.host_resp_bits  = 32'h0;
         bus.host_req_deq    = 1'b0;
         start               = 1'b0;
         resp_now            = pend;
         if (pend) begin
            bus.host_resp_valid = 1'b1;
            bus.host_resp_bits  = pdata;
            pend                = 1'b0;
         end
         if (held > 0) check("valid_hold", {63'h0, bus.host_req_valid}, 64'h1);
         if (bus.host_req_valid) begin
            if (gap_trk) begin
               if (!bus.host_req_opcode && bus.host_req_addr == 8'h00)
                  check("poll_gap", gap_n, POLL_GAP);
               gap_trk = 1'b0;
            end
            if (held == 0)
               snap = {bus.host_req_opcode, bus.host_req_addr, bus.host_req_value};
            else
               check("req_stable", {bus.host_req_opcode, bus.host_req_addr, bus.host_req_value}, snap);
            if (spurious && held == 0 && bus.host_req_opcode && bus.host_req_addr == 8'h10) begin
               bus.host_resp_valid = 1'b1;
               bus.host_resp_bits  = 32'h2;
               start               = 1'b1;
            end
            if (held >= stall) begin
               bus.host_req_deq = 1'b1;
               log_q.push_back({bus.host_req_opcode, bus.host_req_addr, bus.host_req_value});
               if (!bus.host_req_opcode) begin
                  if (bus.host_req_addr == 8'h00) begin
                     polls++;
                     pdata = (polls >= finish_after) ? 32'h2 : 32'h0;
                  end else if (bus.host_req_addr == 8'h04) begin
                     pdata = cnt_val;
                  end else begin
                     pdata = 32'h0;
                  end
                  pend = 1'b1;
               end
               held = 0;
            end else begin
               held++;
            end
         end else if (gap_trk && !resp_now) begin
            gap_n++;
            if (spurious && gap_n == 2) begin
               bus.host_resp_valid = 1'b1;
               bus.host_resp_bits  = 32'h2;
               start               = 1'b1;
            end
         end
         if (resp_now) begin
            gap_trk = 1'b1;
            gap_n   = 0;
         end
         if (done)    n_done++;
         if (timeout) n_to++;
         if (busy) seen_busy = 1'b1;
         else if (seen_busy) fin = 1'b1;
         if (stop_xfers > 0 && log_q.size() >= stop_xfers) fin = 1'b1;
      end
      if (!fin) check("serve_budget", 64'h0, 64'h1);
   endtask

   task automatic check_log(input string name, input int n_polls, input bit with_cnt);
      logic [40:0] exp_q[$];
      exp_q.push_back({1'b1, 8'h08, 32'd5});
      exp_q.push_back({1'b1, 8'h0c, 32'd16});
      exp_q.push_back({1'b1, 8'h10, 32'h2000});
      exp_q.push_back({1'b1, 8'h14, 32'h1});
      exp_q.push_back({1'b1, 8'h18, 32'h4000});
      exp_q.push_back({1'b1, 8'h1c, 32'h3});
      exp_q.push_back({1'b1, 8'h00, 32'h1});
      for (int i = 0; i < n_polls; i++) exp_q.push_back({1'b0, 8'h00, 32'h0});
      if (with_cnt) exp_q.push_back({1'b0, 8'h04, 32'h0});
      exp_q.push_back({1'b1, 8'h00, 32'h0});
      check({name, "_log_size"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check($sformatf("%s_log%0d", name, i), log_q[i], exp_q[i]);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_valid"},   bus.host_req_valid,  64'h0);
      check({name, "_opcode"},  bus.host_req_opcode, 64'h0);
      check({name, "_addr"},    bus.host_req_addr,   64'h0);
      check({name, "_value"},   bus.host_req_value,  64'h0);
      check({name, "_busy"},    busy,                64'h0);
      check({name, "_done"},    done,                64'h0);
      check({name, "_timeout"}, timeout,             64'h0);
      check({name, "_cycles"},  cycles,              64'h0);
   endtask

   initial begin
      reset               = 1'b1;
      start               = 1'b0;
      bus.host_req_deq    = 1'b0;
      bus.host_resp_valid = 1'b0;
      bus.host_resp_bits  = 32'h0;
      cfg_constant        = 32'd5;
      cfg_length          = 32'd16;
      cfg_inp_baddr       = 64'h1_0000_2000;
      cfg_out_baddr       = 64'h3_0000_4000;
      n_done              = 0;
      n_to                = 0;
      repeat (3) @(negedge clock);
      check_reset_state("rst");
      reset = 1'b0;

      // nominal run: three polls, counter 0x64
      launch();
      serve(0, 3, 32'h64, 0, 1'b0, 400);
      check_log("nom", 3, 1'b1);
      check("nom_cycles",  cycles, 64'h64);
      check("nom_done",    n_done, 64'h1);
      check("nom_timeout", n_to,   64'h0);

      // backpressure: deq low for 3 cycles on every request
      launch();
      serve(3, 3, 32'h77, 0, 1'b0, 600);
      check_log("bp", 3, 1'b1);
      check("bp_cycles", cycles, 64'h77);
      check("bp_done",   n_done, 64'h1);

      // timeout: finish bit never set
      launch();
      serve(0, 1000, 32'h55, 0, 1'b0, 400);
      check_log("to", MAX_POLLS, 1'b0);
      check("to_timeout", n_to,   64'h1);
      check("to_done",    n_done, 64'h0);
      check("to_cycles",  cycles, 64'h77);

      // spurious responses and starts during WRITE and GAP
      launch();
      serve(0, 3, 32'h64, 0, 1'b1, 400);
      check_log("spur", 3, 1'b1);
      check("spur_cycles", cycles, 64'h64);
      check("spur_done",   n_done, 64'h1);

      // reset right after the 0x0c write is accepted
      launch();
      serve(0, 3, 32'h64, 2, 1'b0, 100);
      @(posedge clock);
      @(negedge clock);
      bus.host_req_deq = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check_reset_state("midrst");
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check($sformatf("postrst_valid%0d", i), bus.host_req_valid, 64'h0);
         bus.host_resp_valid = (i == 2);
      end
      bus.host_resp_valid = 1'b0;
      launch();
      serve(0, 3, 32'h99, 0, 1'b0, 400);
      check_log("restart", 3, 1'b1);
      check("restart_cycles", cycles, 64'h99);
      check("restart_done",   n_done, 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
